// File: rtl/k6502_bus_trace_if.sv
// Bus-trace control/capture/readout bundle between the k6502 harness and the trace buffer.
// Latency: none (wires only).
// Backpressure: none; readout is host-paced via rd_en, capture never stalls the CPU.
interface k6502_bus_trace_if #(
    parameter int AW         = 16,
    parameter int DW         = 8,
    parameter int DEPTH_LOG2 = 6
);
    logic                  arm;
    logic [AW-1:0]         trig_addr;
    logic [AW-1:0]         trig_mask;
    logic                  trig_on_sync;
    logic [DEPTH_LOG2-1:0] post_count;
    logic [AW-1:0]         a;
    logic [DW-1:0]         d;
    logic                  rw;
    logic                  sync;
    logic                  armed;
    logic                  triggered;
    logic                  done;
    logic [DEPTH_LOG2:0]   level;
    logic                  rd_en;
    logic [AW+DW+1:0]      rd_data;
    logic                  rd_valid;

    // Harness side: drives control, bus snoop and pops; observes status/readout.
    modport master (
        output arm, trig_addr, trig_mask, trig_on_sync, post_count,
        output a, d, rw, sync, rd_en,
        input  armed, triggered, done, level, rd_data, rd_valid
    );

    // Trace buffer side.
    modport slave (
        input  arm, trig_addr, trig_mask, trig_on_sync, post_count,
        input  a, d, rw, sync, rd_en,
        output armed, triggered, done, level, rd_data, rd_valid
    );
endinterface

// File: rtl/k6502_bus_trace.sv
// Circular bus-cycle trace buffer: captures {sync,rw,a,d} every cycle, stops post_count cycles after a trigger.
// Latency: capture writes on the sampling edge; readout data/valid appear one cycle after rd_en.
// Backpressure: none on capture (oldest entries overwritten); readout pops only in DONE with level>0.
module k6502_bus_trace #(
    parameter int AW         = 16,
    parameter int DW         = 8,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    k6502_bus_trace_if.slave  bus
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int EW    = AW + DW + 2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_POST,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [DEPTH_LOG2-1:0] remain_q, remain_d;
    logic [EW-1:0]         rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    logic [EW-1:0]         mem [DEPTH];

    logic                  hit;
    logic                  wr_en;
    logic [EW-1:0]         entry;
    logic [DEPTH_LOG2-1:0] wr_ptr_nx;
    logic [DEPTH_LOG2:0]   level_wr;
    logic [DEPTH_LOG2-1:0] oldest_ptr;

    // Masked address compare, optionally qualified by opcode fetch.
    assign hit = (((bus.a ^ bus.trig_addr) & bus.trig_mask) == '0) &&
                 (!bus.trig_on_sync || bus.sync);

    assign entry     = {bus.sync, bus.rw, bus.a, bus.d};
    assign wr_ptr_nx = wr_ptr_q + 1'b1;
    // Level saturates at DEPTH: once full, each write replaces the oldest entry.
    assign level_wr  = (level_q == LEVEL_FULL) ? level_q : level_q + 1'b1;
    // Oldest entry after the final write; a full buffer truncates level to 0, giving wr_ptr_nx.
    assign oldest_ptr = wr_ptr_nx - level_wr[DEPTH_LOG2-1:0];

    // Next-state: arm overrides everything, then capture/trigger/readout per state.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        remain_d   = remain_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        wr_en      = 1'b0;

        if (bus.arm) begin
            state_d  = ST_PRE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            unique case (state_q)
                ST_PRE: begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_nx;
                    level_d  = level_wr;
                    if (hit) begin
                        if (bus.post_count == '0) begin
                            state_d  = ST_DONE;
                            rd_ptr_d = oldest_ptr;
                        end else begin
                            state_d  = ST_POST;
                            remain_d = bus.post_count;
                        end
                    end
                end
                ST_POST: begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_nx;
                    level_d  = level_wr;
                    remain_d = remain_q - 1'b1;
                    // remain_q==1 means this write is the last post-trigger cycle.
                    if (remain_q <= 1) begin
                        state_d  = ST_DONE;
                        rd_ptr_d = oldest_ptr;
                    end
                end
                ST_DONE: begin
                    if (bus.rd_en && (level_q != '0)) begin
                        rd_data_d  = mem[rd_ptr_q];
                        rd_valid_d = 1'b1;
                        rd_ptr_d   = rd_ptr_q + 1'b1;
                        level_d    = level_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Control/status registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            remain_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            remain_q   <= remain_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Trace memory write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= entry;
        end
    end

    assign bus.armed     = (state_q == ST_PRE)  || (state_q == ST_POST);
    assign bus.triggered = (state_q == ST_POST) || (state_q == ST_DONE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.level     = level_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
endmodule

// File: tb/tb_k6502_bus_trace.sv
// Directed bench for k6502_bus_trace at DEPTH_LOG2=3 (8 entries).
// Latency: drives inputs 1ns after each rising edge, samples outputs at the same point.
// Backpressure: readout paced by rd_en from the bench.
module tb_k6502_bus_trace;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int DL = 3;

    logic core_clk;
    logic arst_n;
    int   n_checks;
    int   n_errors;
    int   last_n;

    k6502_bus_trace_if #(.AW(AW), .DW(DW), .DEPTH_LOG2(DL)) bus ();

    k6502_bus_trace #(.AW(AW), .DW(DW), .DEPTH_LOG2(DL)) dut (
        .clk   (core_clk),
        .rst_n (arst_n),
        .bus   (bus.slave)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [25:0] ent(input logic s, input logic r, input logic [15:0] a, input logic [7:0] d);
        return {s, r, a, d};
    endfunction

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic r, input logic s);
        bus.a    = a;
        bus.d    = d;
        bus.rw   = r;
        bus.sync = s;
        bus.arm  = 1'b0;
        tick();
    endtask

    // Arm cycle carries a junk bus value that must never appear in the trace.
    task automatic do_arm();
        bus.arm  = 1'b1;
        bus.a    = 16'hDEAD;
        bus.d    = 8'hEE;
        bus.rw   = 1'b0;
        bus.sync = 1'b1;
        tick();
        bus.arm  = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [25:0] exp);
        bus.rd_en = 1'b1;
        tick();
        chk_eq({tag, "_vld"}, bus.rd_valid, 1'b1);
        chk_eq({tag, "_dat"}, bus.rd_data, exp);
    endtask

    // Drives base+n, d=n, rw=1, sync=0 until done rises or the budget runs out.
    task automatic run_seq(input logic [15:0] base, input int max_n, output int last);
        last = -1;
        for (int n = 0; n < max_n; n++) begin
            cyc(base + 16'(n), 8'(n), 1'b1, 1'b0);
            if (bus.done) begin
                last = n;
                break;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        arst_n           = 1'b0;
        bus.arm          = 1'b0;
        bus.trig_addr    = 16'h8005;
        bus.trig_mask    = 16'hFFFF;
        bus.trig_on_sync = 1'b0;
        bus.post_count   = 3'd2;
        bus.a            = '0;
        bus.d            = '0;
        bus.rw           = 1'b0;
        bus.sync         = 1'b0;
        bus.rd_en        = 1'b0;
        tick();
        tick();
        chk_eq("rst_armed", bus.armed, 1'b0);
        chk_eq("rst_trig", bus.triggered, 1'b0);
        chk_eq("rst_done", bus.done, 1'b0);
        chk_eq("rst_level", bus.level, 4'd0);
        chk_eq("rst_rdvld", bus.rd_valid, 1'b0);
        chk_eq("rst_rddat", bus.rd_data, 26'd0);
        arst_n = 1'b1;
        tick();

        // 1: trigger at 0x8005, two post cycles, exactly full.
        do_arm();
        chk_eq("t1_armed", bus.armed, 1'b1);
        run_seq(16'h8000, 20, last_n);
        chk_eq("t1_done_at", 64'(last_n), 64'd7);
        chk_eq("t1_level", bus.level, 4'd8);
        chk_eq("t1_trig", bus.triggered, 1'b1);
        for (int n = 0; n < 8; n++)
            pop_chk($sformatf("t1_pop%0d", n), ent(1'b0, 1'b1, 16'h8000 + 16'(n), 8'(n)));
        bus.rd_en = 1'b0;
        tick();
        chk_eq("t1_vld_end", bus.rd_valid, 1'b0);
        chk_eq("t1_level_end", bus.level, 4'd0);

        // 2: trigger at 0x800C, one post cycle, wraps and overwrites.
        bus.trig_addr  = 16'h800C;
        bus.post_count = 3'd1;
        do_arm();
        run_seq(16'h8000, 30, last_n);
        chk_eq("t2_done_at", 64'(last_n), 64'd13);
        chk_eq("t2_level", bus.level, 4'd8);
        for (int n = 6; n < 14; n++)
            pop_chk($sformatf("t2_pop%0d", n), ent(1'b0, 1'b1, 16'h8000 + 16'(n), 8'(n)));
        bus.rd_en = 1'b0;
        tick();

        // 3: sync-qualified trigger.
        bus.trig_addr    = 16'h8003;
        bus.trig_on_sync = 1'b1;
        bus.post_count   = 3'd0;
        do_arm();
        cyc(16'h8003, 8'h11, 1'b1, 1'b0);
        chk_eq("t3_nosync_trig", bus.triggered, 1'b0);
        chk_eq("t3_nosync_armed", bus.armed, 1'b1);
        cyc(16'h8001, 8'h22, 1'b1, 1'b0);
        cyc(16'h8003, 8'h33, 1'b1, 1'b1);
        chk_eq("t3_done", bus.done, 1'b1);
        chk_eq("t3_level", bus.level, 4'd3);
        pop_chk("t3_pop0", ent(1'b0, 1'b1, 16'h8003, 8'h11));
        pop_chk("t3_pop1", ent(1'b0, 1'b1, 16'h8001, 8'h22));
        pop_chk("t3_pop2", ent(1'b1, 1'b1, 16'h8003, 8'h33));
        chk_eq("t3_syncbit", bus.rd_data[25], 1'b1);
        bus.rd_en = 1'b0;
        tick();

        // 4: zero mask, zero post count.
        bus.trig_mask    = 16'h0000;
        bus.trig_on_sync = 1'b0;
        do_arm();
        cyc(16'h1234, 8'hAB, 1'b0, 1'b1);
        chk_eq("t4_done", bus.done, 1'b1);
        chk_eq("t4_level", bus.level, 4'd1);
        pop_chk("t4_pop", ent(1'b1, 1'b0, 16'h1234, 8'hAB));
        tick();
        chk_eq("t4_empty_vld", bus.rd_valid, 1'b0);
        chk_eq("t4_hold_dat", bus.rd_data, ent(1'b1, 1'b0, 16'h1234, 8'hAB));
        chk_eq("t4_level_end", bus.level, 4'd0);
        bus.rd_en = 1'b0;
        tick();

        // 5: re-arm during POST, then during readout.
        bus.trig_mask  = 16'hFFFF;
        bus.trig_addr  = 16'h8002;
        bus.post_count = 3'd5;
        do_arm();
        for (int n = 0; n < 4; n++) cyc(16'h8000 + 16'(n), 8'(n), 1'b1, 1'b0);
        chk_eq("t5_in_post_trig", bus.triggered, 1'b1);
        chk_eq("t5_in_post_done", bus.done, 1'b0);
        bus.trig_addr  = 16'h9003;
        bus.post_count = 3'd1;
        do_arm();
        chk_eq("t5a_level", bus.level, 4'd0);
        chk_eq("t5a_armed", bus.armed, 1'b1);
        chk_eq("t5a_trig", bus.triggered, 1'b0);
        cyc(16'h9000, 8'h00, 1'b1, 1'b0);
        chk_eq("t5a_restart", bus.level, 4'd1);
        for (int n = 1; n < 5; n++) cyc(16'h9000 + 16'(n), 8'(n), 1'b1, 1'b0);
        chk_eq("t5b_done", bus.done, 1'b1);
        chk_eq("t5b_level", bus.level, 4'd5);
        for (int n = 0; n < 3; n++)
            pop_chk($sformatf("t5b_pop%0d", n), ent(1'b0, 1'b1, 16'h9000 + 16'(n), 8'(n)));
        bus.rd_en = 1'b0;
        do_arm();
        chk_eq("t5c_level", bus.level, 4'd0);
        chk_eq("t5c_armed", bus.armed, 1'b1);
        chk_eq("t5c_trig", bus.triggered, 1'b0);
        chk_eq("t5c_vld", bus.rd_valid, 1'b0);
        cyc(16'hA000, 8'h55, 1'b1, 1'b0);
        chk_eq("t5c_restart", bus.level, 4'd1);

        // 6: asynchronous reset mid-POST.
        bus.trig_addr  = 16'h8001;
        bus.post_count = 3'd5;
        do_arm();
        for (int n = 0; n < 3; n++) cyc(16'h8000 + 16'(n), 8'(n), 1'b1, 1'b0);
        chk_eq("t6_pre_trig", bus.triggered, 1'b1);
        #3;
        arst_n = 1'b0;
        #1;
        chk_eq("t6_armed", bus.armed, 1'b0);
        chk_eq("t6_trig", bus.triggered, 1'b0);
        chk_eq("t6_done", bus.done, 1'b0);
        chk_eq("t6_level", bus.level, 4'd0);
        chk_eq("t6_rdvld", bus.rd_valid, 1'b0);
        chk_eq("t6_rddat", bus.rd_data, 26'd0);
        tick();
        tick();
        arst_n    = 1'b1;
        bus.rd_en = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk_eq($sformatf("t6_post_vld%0d", n), bus.rd_valid, 1'b0);
            chk_eq($sformatf("t6_post_lvl%0d", n), bus.level, 4'd0);
        end
        bus.rd_en = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
